scene_loader: RTL and testbench
===============================

// Module: scene_loader
// PURPOSE
//  Byte-stream front end that feeds a scene into physics_engine's initial-state inputs.
//  Receives a framed scene over an 8-bit valid/ready stream (UART/host bridge side).
//  Assembles per-sprite position, velocity, mass and radius into shadow registers.
//  On a complete, good frame: commits the shadows to the outputs and pulses data_ready for 1 cycle.
// PARAMETERS
//  SPRITES     9   number of sprites per frame (>=1)
//  WIDTH       32  bits per location/velocity component (multiple of 16); mass is WIDTH/2
//  DIMENSIONS  2   components per vector (x=0, y=1)
// PORTS
//  clk_162         in   1                         system clock; all logic on posedge
//  rst             in   1                         synchronous reset, active-high
//  in_data         in   8                         stream byte
//  in_valid        in   1                         in_data valid
//  in_ready        out  1                         byte accepted on cycle where in_valid&in_ready
//  init_locations  out  SPRITES*DIMENSIONS*WIDTH  committed positions [s][d]
//  init_velos      out  SPRITES*DIMENSIONS*WIDTH  committed velocities [s][d]
//  masses          out  SPRITES*WIDTH/2           committed masses
//  radii           out  SPRITES*7                 committed radii
//  data_ready      out  1                         1-cycle pulse; outputs valid from this cycle on
//  busy            out  1                         frame in progress (state != IDLE)
//  frame_error     out  1                         1-cycle pulse; frame discarded
// BEHAVIOUR
//  Frame: 0xA5 header, then per sprite s=0..SPRITES-1, BPS = DIMENSIONS*WIDTH/4 + WIDTH/16 + 1 bytes
//   (19 at defaults): loc[d] for d=0..DIMENSIONS-1, then velo[d], then mass, then radius.
//   Each multi-byte field is little-endian; radius byte bit 7 is ignored.
//  States:
//   IDLE: in_ready=1; 0xA5 -> LOAD (sprite_idx=0, byte_idx=0, cksum=0); any other byte dropped silently.
//   LOAD: in_ready=1; each accepted byte is written to the shadow field at [sprite_idx][byte_idx] and XORed into cksum.
//         byte_idx wraps BPS-1 -> 0 and sprite_idx increments.
//         Last byte of sprite SPRITES-1 -> CHECK (with CKSUM_EN) or COMMIT (without).
//   CHECK: in_ready=1; accepted byte b: (cksum^b)==0 -> COMMIT, else -> IDLE with frame_error pulsed next cycle.
//   COMMIT: in_ready=0 for exactly 1 cycle; outputs <= shadows; data_ready=1 during this cycle; -> IDLE.
//  Latency: data_ready is high in the cycle after the final frame byte is accepted.
//  Outputs are held between commits; a partial or bad frame never alters them.
//  A 0xA5 byte inside LOAD is payload, not a resync.
//  Stall: in_valid low at any point just holds state; no timeout.
//  Reset mid-frame: state=IDLE; shadows, outputs and counters cleared; in_ready=0 only during the rst cycle.
//  Reset values: all outputs 0 (init_locations, init_velos, masses, radii, data_ready, busy, frame_error), state IDLE.
//  frame_error and data_ready are never high in the same cycle.
// CONFIGURATION
//  SCENE_LOADER_CKSUM_EN defined:
//   - A trailing XOR checksum byte follows the payload; frame length = 1 + SPRITES*BPS + 1.
//   - Mismatch -> frame discarded + frame_error.
//  SCENE_LOADER_CKSUM_EN undefined:
//   - No CHECK state; frame length = 1 + SPRITES*BPS.
//   - Last payload byte -> COMMIT; frame_error is tied 0.
// TESTING
//  1. Good frame, CKSUM_EN, in_valid held high: s0 loc=(0x00001000,0x00002000), velo=(0x10,0xFFFFFFF0), mass=0x0C00, radius=0x05; other sprites 0.
//     -> data_ready 1 cycle after last byte; outputs match exactly; in_ready=0 in the COMMIT cycle.
//  2. Corrupt checksum (flip bit 0) after a committed frame A
//     -> frame_error pulses once, data_ready stays 0, outputs still equal frame A.
//  3. Garbage 0x00,0x13,0xFF before 0xA5, plus random in_valid gaps inside the frame
//     -> leading bytes ignored, busy rises on 0xA5, commit identical to gap-free run.
//  4. rst asserted after 40 payload bytes, then a full good frame
//     -> outputs 0 after rst, no data_ready until the new frame completes, then correct values.
//  5. Payload containing 0xA5 at byte 3 of sprite 2 -> treated as data; commit correct.
//  6. CKSUM_EN undefined build
//     -> commit 1 cycle after byte 1+9*19=172; frame_error never asserts.

Source files
------------

// File: rtl/scene_loader.sv
// scene_loader: assembles a framed byte stream into shadow registers and commits them as physics initial state.
// Define SCENE_LOADER_CKSUM_EN to require a trailing XOR checksum byte (frame_error on mismatch).
module scene_loader #(
    parameter int SPRITES    = 9,
    parameter int WIDTH      = 32,
    parameter int DIMENSIONS = 2
) (
    input  logic                                clk_162,
    input  logic                                rst,
    input  logic [7:0]                          in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_locations,
    output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_velos,
    output logic [SPRITES*WIDTH/2-1:0]          masses,
    output logic [SPRITES*7-1:0]                radii,
    output logic                                data_ready,
    output logic                                busy,
    output logic                                frame_error
);
    localparam int LB  = DIMENSIONS * WIDTH / 8;
    localparam int MB  = WIDTH / 16;
    localparam int BPS = 2 * LB + MB + 1;
    localparam int BW  = $clog2(BPS);
    localparam int SW  = SPRITES > 1 ? $clog2(SPRITES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;
`ifdef SCENE_LOADER_CKSUM_EN
    localparam state_t AFTER_LOAD = CHECK;
`else
    localparam state_t AFTER_LOAD = COMMIT;
`endif

    state_t state, nxt;
    logic [SW-1:0] sprite_idx;
    logic [BW-1:0] byte_idx;
    logic acc, wr, byte_last, last, go;

    assign acc       = in_valid && in_ready;
    assign wr        = acc && state == LOAD;
    assign byte_last = byte_idx == BW'(BPS - 1);
    assign last      = byte_last && sprite_idx == SW'(SPRITES - 1);
    assign go        = nxt == COMMIT;

`ifdef SCENE_LOADER_CKSUM_EN
    logic [7:0] cksum;
    logic       bad;
    assign bad = (cksum ^ in_data) != 8'h00;
    always_ff @(posedge clk_162) begin
        if (rst) begin
            cksum       <= 8'h00;
            frame_error <= 1'b0;
        end else begin
            cksum       <= state == IDLE ? 8'h00 : wr ? cksum ^ in_data : cksum;
            frame_error <= state == CHECK && acc && bad;
        end
    end
`else
    assign frame_error = 1'b0;
`endif

    always_ff @(posedge clk_162) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt        = state;
        in_ready   = !rst && state != COMMIT;
        busy       = state != IDLE;
        data_ready = state == COMMIT;
        case (state)
            IDLE:    nxt = acc && in_data == 8'hA5 ? LOAD : IDLE;
            LOAD:    nxt = acc && last ? AFTER_LOAD : LOAD;
`ifdef SCENE_LOADER_CKSUM_EN
            CHECK:   nxt = acc ? (bad ? IDLE : COMMIT) : CHECK;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_162) begin
        if (rst || (state == IDLE && acc)) begin
            sprite_idx <= '0;
            byte_idx   <= '0;
        end else if (wr) begin
            byte_idx   <= byte_last ? '0 : byte_idx + 1'b1;
            sprite_idx <= sprite_idx + SW'(byte_last);
        end
    end

    // Commit captures the post-write shadow so outputs are already valid while data_ready is high.
    for (genvar s = 0; s < SPRITES; s++) begin : g_spr
        logic [LB-1:0][7:0] sh_loc, sh_vel, loc_n, vel_n, c_loc, c_vel;
        logic [MB-1:0][7:0] sh_mass, mass_n, c_mass;
        logic [6:0]         sh_rad, rad_n, c_rad;
        logic               we;
        assign we = wr && sprite_idx == SW'(s);
        always_comb begin
            loc_n  = sh_loc;
            vel_n  = sh_vel;
            mass_n = sh_mass;
            rad_n  = we && byte_idx == BW'(BPS - 1) ? in_data[6:0] : sh_rad;
            for (int k = 0; k < LB; k++) begin
                if (we && byte_idx == BW'(k)) loc_n[k] = in_data;
                if (we && byte_idx == BW'(LB + k)) vel_n[k] = in_data;
            end
            for (int k = 0; k < MB; k++)
                if (we && byte_idx == BW'(2 * LB + k)) mass_n[k] = in_data;
        end
        always_ff @(posedge clk_162) begin
            if (rst) begin
                {sh_loc, sh_vel, sh_mass, sh_rad} <= '0;
                {c_loc, c_vel, c_mass, c_rad}     <= '0;
            end else begin
                {sh_loc, sh_vel, sh_mass, sh_rad} <= {loc_n, vel_n, mass_n, rad_n};
                if (go) {c_loc, c_vel, c_mass, c_rad} <= {loc_n, vel_n, mass_n, rad_n};
            end
        end
        assign init_locations[s*LB*8 +: LB*8] = c_loc;
        assign init_velos[s*LB*8 +: LB*8]     = c_vel;
        assign masses[s*MB*8 +: MB*8]         = c_mass;
        assign radii[s*7 +: 7]                = c_rad;
    end
endmodule

// File: tb/tb_scene_loader.sv
// tb_scene_loader: directed frames against scene_loader at default parameters.
// Follows SCENE_LOADER_CKSUM_EN the same way the design does.
module tb_scene_loader;
`ifdef SCENE_LOADER_CKSUM_EN
    localparam int FLEN = 173;
    localparam int FE_EXP = 1;
`else
    localparam int FLEN = 172;
    localparam int FE_EXP = 0;
`endif

    logic         clk_162 = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_ready, data_ready, busy, frame_error;
    logic [575:0] init_locations, init_velos;
    logic [143:0] masses;
    logic [62:0]  radii;

    int total = 0, bad = 0, dr_cnt = 0, fe_cnt = 0, both_cnt = 0, len = 0, cnt0 = 0;
    logic [31:0]  m_loc [9][2], m_vel [9][2];
    logic [15:0]  m_mass [9];
    logic [7:0]   m_rad [9];
    logic [575:0] x_loc, x_vel, a_loc, a_vel;
    logic [143:0] x_mass, a_mass;
    logic [62:0]  x_rad, a_rad;

    scene_loader dut (
        .clk_162(clk_162), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .init_locations(init_locations), .init_velos(init_velos), .masses(masses), .radii(radii),
        .data_ready(data_ready), .busy(busy), .frame_error(frame_error)
    );

    always #5 clk_162 = ~clk_162;

    always @(posedge clk_162) begin
        if (data_ready) dr_cnt++;
        if (frame_error) fe_cnt++;
        if (data_ready && frame_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk_162);
            n++;
        end
        if (n == 50) check("push_ready", in_ready, 1'b1);
        @(negedge clk_162);
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk_162);
    endtask

    task automatic clear_model();
        for (int s = 0; s < 9; s++) begin
            m_loc[s] = '{32'h0, 32'h0};
            m_vel[s] = '{32'h0, 32'h0};
            m_mass[s] = 16'h0;
            m_rad[s] = 8'h0;
        end
    endtask

    task automatic rand_model();
        for (int s = 0; s < 9; s++) begin
            m_loc[s] = '{$urandom, $urandom};
            m_vel[s] = '{$urandom, $urandom};
            m_mass[s] = 16'($urandom);
            m_rad[s] = 8'($urandom);
        end
    endtask

    task automatic calc_exp();
        for (int s = 0; s < 9; s++) begin
            for (int d = 0; d < 2; d++) begin
                x_loc[(s*2+d)*32 +: 32] = m_loc[s][d];
                x_vel[(s*2+d)*32 +: 32] = m_vel[s][d];
            end
            x_mass[s*16 +: 16] = m_mass[s];
            x_rad[s*7 +: 7] = m_rad[s][6:0];
        end
    endtask

    task automatic send_frame(input bit gaps, input bit corrupt);
        logic [7:0] p[$];
        logic [7:0] x = 8'h00;
        for (int s = 0; s < 9; s++) begin
            for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) p.push_back(m_loc[s][d][8*k +: 8]);
            for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) p.push_back(m_vel[s][d][8*k +: 8]);
            for (int k = 0; k < 2; k++) p.push_back(m_mass[s][8*k +: 8]);
            p.push_back(m_rad[s]);
        end
        len = 0;
        push(8'hA5);
        len++;
        check("busy_on_hdr", busy, 1'b1);
        foreach (p[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
            push(p[i]);
            x ^= p[i];
            len++;
        end
`ifdef SCENE_LOADER_CKSUM_EN
        push(x ^ {7'd0, corrupt});
        len++;
`else
        x ^= {7'd0, corrupt};
`endif
        in_valid = 1'b0;
    endtask

    task automatic expect_commit(input string tag);
        calc_exp();
        check({tag, "_len"}, len, FLEN);
        check({tag, "_dr"}, data_ready, 1'b1);
        check({tag, "_rdy_commit"}, in_ready, 1'b0);
        check({tag, "_fe"}, frame_error, 1'b0);
        check({tag, "_loc"}, init_locations, x_loc);
        check({tag, "_vel"}, init_velos, x_vel);
        check({tag, "_mass"}, masses, x_mass);
        check({tag, "_rad"}, radii, x_rad);
        @(negedge clk_162);
        check({tag, "_dr_off"}, data_ready, 1'b0);
        check({tag, "_busy_off"}, busy, 1'b0);
        check({tag, "_loc_hold"}, init_locations, x_loc);
    endtask

    initial begin
        repeat (2) @(negedge clk_162);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_loc", init_locations, 0);
        check("rst_vel", init_velos, 0);
        check("rst_mass", masses, 0);
        check("rst_rad", radii, 0);
        check("rst_flags", {data_ready, busy, frame_error}, 3'b000);
        rst = 1'b0;
        @(negedge clk_162);
        check("idle_ready", in_ready, 1'b1);

        // 1: hand-built scene, in_valid held high
        clear_model();
        m_loc[0] = '{32'h0000_1000, 32'h0000_2000};
        m_vel[0] = '{32'h0000_0010, 32'hFFFF_FFF0};
        m_mass[0] = 16'h0C00;
        m_rad[0] = 8'h05;
        send_frame(1'b0, 1'b0);
        check("t1_loc_s0", init_locations[63:0], 64'h0000_2000_0000_1000);
        check("t1_loc_rest", init_locations[575:64], 0);
        check("t1_vel_s0", init_velos[63:0], 64'hFFFF_FFF0_0000_0010);
        check("t1_mass_s0", masses[15:0], 16'h0C00);
        check("t1_rad_s0", radii[6:0], 7'h05);
        expect_commit("t1");
        calc_exp();
        {a_loc, a_vel, a_mass, a_rad} = {x_loc, x_vel, x_mass, x_rad};
        check("t1_dr_cnt", dr_cnt, 1);

`ifdef SCENE_LOADER_CKSUM_EN
        // 2: bad checksum must leave frame A in place
        rand_model();
        send_frame(1'b0, 1'b1);
        check("t2_fe", frame_error, 1'b1);
        check("t2_dr", data_ready, 1'b0);
        check("t2_busy", busy, 1'b0);
        @(negedge clk_162);
        check("t2_fe_off", frame_error, 1'b0);
        check("t2_fe_cnt", fe_cnt, 1);
        check("t2_dr_cnt", dr_cnt, 1);
        check("t2_hold", {init_locations, init_velos, masses, radii}, {a_loc, a_vel, a_mass, a_rad});
`endif

        // 3: leading garbage, then a frame with random stalls
        push(8'h00);
        check("t3_g0_busy", busy, 1'b0);
        push(8'h13);
        check("t3_g1_busy", busy, 1'b0);
        push(8'hFF);
        check("t3_g2_busy", busy, 1'b0);
        rand_model();
        send_frame(1'b1, 1'b0);
        expect_commit("t3");

        // 4: reset in the middle of a frame
        rand_model();
        push(8'hA5);
        for (int i = 0; i < 40; i++) push(8'(i * 7 + 1));
        in_valid = 1'b0;
        rst = 1'b1;
        #1 check("t4_rst_ready", in_ready, 1'b0);
        @(negedge clk_162);
        rst = 1'b0;
        check("t4_cleared", {init_locations, init_velos, masses, radii}, 0);
        check("t4_busy", busy, 1'b0);
        #1 check("t4_ready", in_ready, 1'b1);
        @(negedge clk_162);
        cnt0 = dr_cnt;
        rand_model();
        send_frame(1'b0, 1'b0);
        check("t4_no_early_dr", dr_cnt, cnt0);
        expect_commit("t4");

        // 5: 0xA5 inside payload, radius bit 7 set
        clear_model();
        m_loc[2] = '{32'hA512_3456, 32'h0BAD_F00D};
        m_mass[2] = 16'hA5A5;
        m_rad[2] = 8'hFF;
        m_rad[8] = 8'h80;
        send_frame(1'b0, 1'b0);
        expect_commit("t5");

        @(negedge clk_162);
        check("fe_total", fe_cnt, FE_EXP);
        check("dr_total", dr_cnt, 4);
        check("dr_fe_overlap", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
